// File: rtl/reu_bus_pkg.sv
// Shared types and defaults for the C64 host-side bus arbiter.
// Holds the FSM state encoding and the state-to-pin decode.
package reu_bus_pkg;

  localparam int CLKDIV_DEF   = 8;
  localparam int BA_DELAY_DEF = 3;

  typedef enum logic [2:0] {
    RUN,
    VIC_WAIT,
    VIC_OWN,
    DMA_WAIT,
    DMA_OWN
  } arb_state_t;

  typedef struct packed {
    logic ba;
    logic aec;
    logic rdy;
    logic cpu_halted;
    logic dma_grant;
  } bus_out_t;

  // resume_dma marks a VIC steal that interrupted a DMA transfer; the CPU stays parked then
  function automatic bus_out_t outs_of(arb_state_t s, logic resume_dma);
    bus_out_t o;
    o.ba         = !(s == VIC_WAIT || s == VIC_OWN);
    o.rdy        = (s == RUN);
    o.aec        = !((s == VIC_OWN) || (s == DMA_OWN) || (s == VIC_WAIT && resume_dma));
    o.cpu_halted = (s == DMA_OWN) || (s == VIC_OWN) || (s == VIC_WAIT && resume_dma);
    o.dma_grant  = (s == DMA_OWN);
    return o;
  endfunction

endpackage

// File: rtl/c64_bus_arbiter_if.sv
// Expansion-port / VIC / CPU bus signals seen by the arbiter.
// slave = the arbiter itself, master = whoever drives the requests.
interface c64_bus_arbiter_if;
  logic        nDMA;
  logic        VicReq;
  logic        CpuRnW;
  logic        PHI2;
  logic        BA;
  logic        AEC;
  logic        RDY;
  logic        CpuHalted;
  logic        DmaGrant;
  logic [15:0] DmaCycles;

  modport master (
    output nDMA, VicReq, CpuRnW,
    input  PHI2, BA, AEC, RDY, CpuHalted, DmaGrant, DmaCycles
  );

  modport slave (
    input  nDMA, VicReq, CpuRnW,
    output PHI2, BA, AEC, RDY, CpuHalted, DmaGrant, DmaCycles
  );
endinterface

// File: rtl/phi2_gen.sv
// Divides C8M into PHI2 and flags the last C8M cycle of each PHI2 cycle.
// PHI2 is registered so it is glitch-free and falls exactly on the wrap edge.
module phi2_gen #(
  parameter int CLKDIV = 8
) (
  input  logic C8M,
  input  logic RESET,
  output logic PHI2,
  output logic boundary
);

  localparam int CW = $clog2(CLKDIV);
  localparam logic [CW-1:0] LAST = CW'(CLKDIV - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKDIV / 2);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;

  assign cnt_inc  = cnt + 1'b1;
  assign boundary = (cnt == LAST);

  always_ff @(posedge C8M or posedge RESET) begin
    if (RESET) begin
      cnt  <= '0;
      PHI2 <= 1'b0;
    end else if (boundary) begin
      cnt  <= '0;
      PHI2 <= 1'b0;
    end else begin
      cnt  <= cnt_inc;
      PHI2 <= (cnt_inc >= HALF);
    end
  end

endmodule

// File: rtl/c64_bus_arbiter.sv
// C64 bus ownership arbiter: CPU vs VIC-II steal vs expansion-port DMA,
// one decision per PHI2 cycle, driving BA/AEC/RDY as the REU expects.
module c64_bus_arbiter
  import reu_bus_pkg::*;
#(
  parameter int CLKDIV   = CLKDIV_DEF,
  parameter int BA_DELAY = BA_DELAY_DEF
) (
  input  logic               C8M,
  input  logic               RESET,
  c64_bus_arbiter_if.slave   bus
);

  localparam logic [1:0] DLY_LOAD = 2'(BA_DELAY - 1);

  logic        boundary;
  arb_state_t  state, nxt;
  logic        resume_dma, nxt_resume;
  logic [1:0]  dly, nxt_dly;
  bus_out_t    outs;
  logic [15:0] dma_cnt;
  arb_state_t  resume_target;

  phi2_gen #(.CLKDIV(CLKDIV)) u_phi2 (
    .C8M      (C8M),
    .RESET    (RESET),
    .PHI2     (bus.PHI2),
    .boundary (boundary)
  );

  // A steal that interrupted DMA only goes back to DMA if the REU still wants the bus
  assign resume_target = (resume_dma && !bus.nDMA) ? DMA_OWN : RUN;

  always_comb begin
    nxt        = state;
    nxt_resume = resume_dma;
    nxt_dly    = dly;
    unique case (state)
      RUN: begin
        if (bus.VicReq) begin
          nxt        = VIC_WAIT;
          nxt_resume = 1'b0;
          nxt_dly    = DLY_LOAD;
        end else if (!bus.nDMA) begin
          nxt = DMA_WAIT;
        end
      end
      VIC_WAIT: begin
        if (!bus.VicReq)   nxt = resume_target;
        else if (dly == 2'd0) nxt = VIC_OWN;
        else               nxt_dly = dly - 2'd1;
      end
      VIC_OWN: begin
        if (!bus.VicReq) nxt = resume_target;
      end
      DMA_WAIT: begin
        if (bus.VicReq) begin
          nxt        = VIC_WAIT;
          nxt_resume = 1'b0;
          nxt_dly    = DLY_LOAD;
        end else if (bus.CpuRnW) begin
          nxt = DMA_OWN;
        end else if (bus.nDMA) begin
          nxt = RUN;
        end
      end
      DMA_OWN: begin
        if (bus.VicReq) begin
          nxt        = VIC_WAIT;
          nxt_resume = 1'b1;
          nxt_dly    = DLY_LOAD;
        end else if (bus.nDMA) begin
          nxt = RUN;
        end
      end
      default: nxt = RUN;
    endcase
  end

  // Outputs are decoded from the next state so they switch on the PHI2 falling edge
  always_ff @(posedge C8M or posedge RESET) begin
    if (RESET) begin
      state      <= RUN;
      resume_dma <= 1'b0;
      dly        <= 2'd0;
      outs       <= outs_of(RUN, 1'b0);
      dma_cnt    <= 16'd0;
    end else if (boundary) begin
      state      <= nxt;
      resume_dma <= nxt_resume;
      dly        <= nxt_dly;
      outs       <= outs_of(nxt, nxt_resume);
      if (state == DMA_OWN && dma_cnt != 16'hFFFF)
        dma_cnt <= dma_cnt + 16'd1;
    end
  end

  assign bus.BA        = outs.ba;
  assign bus.AEC       = outs.aec;
  assign bus.RDY       = outs.rdy;
  assign bus.CpuHalted = outs.cpu_halted;
  assign bus.DmaGrant  = outs.dma_grant;
  assign bus.DmaCycles = dma_cnt;

endmodule

// File: tb/tb_c64_bus_arbiter.sv
// Scoreboard bench for c64_bus_arbiter: a bus-ownership model predicts the
// pins for every PHI2 cycle; a monitor compares on each PHI2 falling edge.
module tb_c64_bus_arbiter;

  localparam int CLKDIV   = 8;
  localparam int BA_DELAY = 3;
  localparam int M_CPU  = 0;
  localparam int M_WAIT = 1;
  localparam int M_DMA  = 2;

  logic C8M   = 1'b0;
  logic RESET = 1'b1;

  c64_bus_arbiter_if bus ();

  c64_bus_arbiter #(.CLKDIV(CLKDIV), .BA_DELAY(BA_DELAY)) dut (
    .C8M   (C8M),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 C8M = ~C8M;

  typedef struct packed {
    logic        ba;
    logic        aec;
    logic        rdy;
    logic        halted;
    logic        grant;
    logic [15:0] cycles;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 0;
  bit   phi_chk = 0;

  // Model: who the bus belongs to, how many cycles the VIC steal is old,
  // whether the steal interrupted DMA, and the granted-cycle tally.
  int m_mode;
  int m_age;
  bit m_from_dma;
  int m_cnt;

  task automatic check(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic void model_reset();
    m_mode = M_CPU;
    m_age = 0;
    m_from_dma = 0;
    m_cnt = 0;
  endfunction

  function automatic exp_t model_expect();
    exp_t e;
    bit waiting, owning, dma_on, parked;
    waiting  = (m_age > 0) && (m_age <= BA_DELAY);
    owning   = (m_age > BA_DELAY);
    dma_on   = (m_age == 0) && (m_mode == M_DMA);
    parked   = owning || dma_on || (waiting && m_from_dma);
    e.ba     = (m_age == 0);
    e.rdy    = (m_age == 0) && (m_mode == M_CPU);
    e.aec    = !parked;
    e.halted = parked;
    e.grant  = dma_on;
    e.cycles = 16'(m_cnt);
    return e;
  endfunction

  function automatic void model_step(bit vic, bit ndma, bit rnw);
    if (m_age == 0 && m_mode == M_DMA && m_cnt < 65535) m_cnt++;
    if (m_age > 0) begin
      if (!vic) begin
        m_age  = 0;
        m_mode = (m_from_dma && !ndma) ? M_DMA : M_CPU;
      end else if (m_age <= BA_DELAY) begin
        m_age++;
      end
    end else if (vic) begin
      m_from_dma = (m_mode == M_DMA);
      m_age      = 1;
      m_mode     = M_CPU;
    end else begin
      case (m_mode)
        M_CPU:  if (!ndma) m_mode = M_WAIT;
        M_WAIT: if (rnw) m_mode = M_DMA; else if (ndma) m_mode = M_CPU;
        M_DMA:  if (ndma) m_mode = M_CPU;
        default: m_mode = M_CPU;
      endcase
    end
  endfunction

  // One PHI2 cycle: inputs change just after a boundary and are sampled on the next one
  task automatic cycle(bit vic, bit ndma, bit rnw);
    bus.VicReq = vic;
    bus.nDMA   = ndma;
    bus.CpuRnW = rnw;
    for (int k = 1; k <= CLKDIV; k++) begin
      @(posedge C8M);
      if (k == CLKDIV) begin
        model_step(vic, ndma, rnw);
        exp_q.push_back(model_expect());
      end
      @(negedge C8M);
      if (phi_chk) check("PHI2", int'(bus.PHI2), int'((k % CLKDIV) >= CLKDIV / 2));
    end
  endtask

  task automatic check_reset_pins(string tag);
    check({tag, "_PHI2"},      int'(bus.PHI2), 0);
    check({tag, "_BA"},        int'(bus.BA), 1);
    check({tag, "_AEC"},       int'(bus.AEC), 1);
    check({tag, "_RDY"},       int'(bus.RDY), 1);
    check({tag, "_CpuHalted"}, int'(bus.CpuHalted), 0);
    check({tag, "_DmaGrant"},  int'(bus.DmaGrant), 0);
    check({tag, "_DmaCycles"}, int'(bus.DmaCycles), 0);
  endtask

  // Monitor: every PHI2 falling edge outside reset must match the oldest prediction
  initial begin
    exp_t e;
    forever begin
      @(negedge bus.PHI2);
      #1;
      if (RESET || !mon_en) continue;
      if (exp_q.size() == 0) begin
        check("unexpected_boundary", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("BA",        int'(bus.BA),        int'(e.ba));
        check("AEC",       int'(bus.AEC),       int'(e.aec));
        check("RDY",       int'(bus.RDY),       int'(e.rdy));
        check("CpuHalted", int'(bus.CpuHalted), int'(e.halted));
        check("DmaGrant",  int'(bus.DmaGrant),  int'(e.grant));
        check("DmaCycles", int'(bus.DmaCycles), int'(e.cycles));
      end
    end
  end

  initial begin
    bit vic, ndma;
    model_reset();
    bus.nDMA   = 1'b1;
    bus.VicReq = 1'b0;
    bus.CpuRnW = 1'b1;
    repeat (3) @(negedge C8M);
    check_reset_pins("reset");
    RESET = 1'b0;
    mon_en = 1;

    // Idle: PHI2 shape and quiescent pins
    phi_chk = 1;
    repeat (3) cycle(0, 1, 1);
    phi_chk = 0;

    // DMA with CPU reads, 10 granted cycles
    for (int i = 0; i < 11; i++) cycle(0, 0, 1);
    repeat (3) cycle(0, 1, 1);
    check("dma_cycles_after_read_burst", int'(bus.DmaCycles), 10);

    // DMA delayed by a three-write burst
    cycle(0, 0, 0);
    repeat (3) cycle(0, 0, 0);
    check("grant_held_off_by_writes", int'(bus.DmaGrant), 0);
    cycle(0, 0, 1);
    check("grant_after_write_burst", int'(bus.DmaGrant), 1);
    repeat (2) cycle(0, 0, 1);
    repeat (2) cycle(0, 1, 1);

    // Long VIC steal in the middle of DMA
    repeat (4) cycle(0, 0, 1);
    repeat (43) cycle(1, 0, 1);
    repeat (3) cycle(0, 0, 1);
    repeat (2) cycle(0, 1, 1);

    // VicReq and nDMA together: VIC first, then the DMA wait
    repeat (6) cycle(1, 0, 1);
    repeat (3) cycle(0, 0, 1);
    repeat (2) cycle(0, 1, 1);

    // nDMA released while the VIC owns the bus
    repeat (3) cycle(0, 0, 1);
    repeat (5) cycle(1, 0, 1);
    repeat (2) cycle(1, 1, 1);
    repeat (2) cycle(0, 1, 1);

    // Randomised traffic with held request levels
    vic = 0;
    ndma = 1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 5) == 0) vic = ~vic;
      if ($urandom_range(0, 4) == 0) ndma = ~ndma;
      cycle(vic, ndma, ($urandom_range(0, 9) < 7));
    end
    repeat (6) cycle(0, 1, 1);

    // Saturation: preload the tally just below the ceiling
    force dut.dma_cnt = 16'hFFFD;
    #1;
    release dut.dma_cnt;
    m_cnt = 65533;
    for (int i = 0; i < 8; i++) cycle(0, 0, 1);
    check("dma_cycles_saturated", int'(bus.DmaCycles), 16'hFFFF);

    // Asynchronous reset in the middle of a granted cycle
    check("grant_before_reset", int'(bus.DmaGrant), 1);
    repeat (3) @(posedge C8M);
    #2;
    RESET = 1'b1;
    #1;
    check_reset_pins("midreset");
    model_reset();
    repeat (2) @(negedge C8M);
    RESET = 1'b0;
    repeat (2) cycle(0, 1, 1);
    for (int i = 0; i < 3; i++) cycle(0, 0, 1);
    repeat (2) cycle(0, 1, 1);

    repeat (4) @(negedge C8M);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
